pb_debounce_bank: RTL and testbench

Parametrised bank of NUM_CH independent push-button channels. Each channel has an input synchroniser, a debounce FSM, one-cycle press, release and long-press pulses, and a per-channel press counter with selectable wrap or saturate mode. It replaces the fixed per-delay debouncer-plus-counter instances that feed the 7-segment driver, and its packed count bus connects directly to the display path.

---
 rtl/pb_debounce_bank.sv | 109 ++++++++++
 tb/tb_pb_debounce_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_bank.sv
// pb_debounce_bank: bank of independent push-button channels, each with a synchroniser,
// debounce FSM, press/release/long-press pulses and a wrap-or-saturate press counter.
module pb_debounce_bank #(
    parameter int NUM_CH      = 4,
    parameter int DELAY       = 5000000,
    parameter int LONG_CYCLES = 100000000,
    parameter int CNT_W       = 8,
    parameter int SATURATE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       pb_in,
    input  logic [NUM_CH-1:0]       clear,
    output logic [NUM_CH-1:0]       pb_level,
    output logic [NUM_CH-1:0]       press_pulse,
    output logic [NUM_CH-1:0]       release_pulse,
    output logic [NUM_CH-1:0]       long_pulse,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       wrap_pulse
);
    localparam int DW = $clog2(DELAY);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_MAX = DW'(DELAY - 1);
    localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    typedef enum logic [1:0] {IDLE, WAIT_HIGH, PRESSED, WAIT_LOW} state_t;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        state_t state_q, state_d;
        logic [DW-1:0] deb_q, deb_d;
        logic [LW-1:0] hold_q, hold_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic fired_q, fired_d, press_q, press_d, rel_q, rel_d, long_q, long_d, wrap_q, wrap_d;
        logic s;
        assign s = sync_q[SYNC_STAGES-1];
        always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], pb_in[g]};
            state_d = state_q;
            deb_d   = deb_q;
            hold_d  = hold_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            // Long press is judged on the frozen timer too, so a bounce in WAIT_LOW cannot hide it
            long_d  = (state_q == PRESSED || state_q == WAIT_LOW) && hold_q == HOLD_MAX && !fired_q;
            fired_d = fired_q || long_d;
            case (state_q)
                IDLE: if (s) begin
                    state_d = WAIT_HIGH;
                    deb_d   = '0;
                end
                WAIT_HIGH: if (!s) state_d = IDLE;
                else if (deb_q == DEB_MAX) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                    fired_d = 1'b0;
                end else deb_d = deb_q + DW'(1);
                PRESSED: if (!s) begin
                    state_d = WAIT_LOW;
                    deb_d   = '0;
                end else if (hold_q != HOLD_MAX) hold_d = hold_q + LW'(1);
                default: if (s) state_d = PRESSED;
                else if (deb_q == DEB_MAX) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else deb_d = deb_q + DW'(1);
            endcase
            wrap_d = !clear[g] && press_q && cnt_q == CNT_ONES && SATURATE == 0;
            cnt_d  = clear[g] ? '0 :
                     !press_q ? cnt_q :
                     cnt_q != CNT_ONES ? cnt_q + CNT_W'(1) :
                     SATURATE != 0 ? cnt_q : '0;
        end
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_q  <= '0;
                state_q <= IDLE;
                deb_q   <= '0;
                hold_q  <= '0;
                cnt_q   <= '0;
                fired_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                state_q <= state_d;
                deb_q   <= deb_d;
                hold_q  <= hold_d;
                cnt_q   <= cnt_d;
                fired_q <= fired_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                wrap_q  <= wrap_d;
            end
        end
        assign pb_level[g]               = state_q == PRESSED || state_q == WAIT_LOW;
        assign press_pulse[g]            = press_q;
        assign release_pulse[g]          = rel_q;
        assign long_pulse[g]             = long_q;
        assign wrap_pulse[g]             = wrap_q;
        assign count[g*CNT_W +: CNT_W]   = cnt_q;
    end
endmodule

// File: tb/tb_pb_debounce_bank.sv
// tb_pb_debounce_bank: directed checks of debounce timing, bounce rejection, long press,
// counter clear/wrap/saturate and reset behaviour, with a scoreboard of expected counts.
module tb_pb_debounce_bank;
    logic clk = 1'b0;
    logic reset;
    logic [1:0] pb, clr;
    logic [1:0] pb_level, press_pulse, release_pulse, long_pulse, wrap_pulse;
    logic [15:0] count;
    logic pb_w, clr_w;
    logic w_level, w_press, w_rel, w_long, w_wrap;
    logic s_level, s_press, s_rel, s_long, s_wrap;
    logic [1:0] w_count, s_count;

    typedef struct {int ch; logic [7:0] cnt; logic wrap;} exp_t;
    exp_t q_main[$], q_w[$], q_s[$];
    exp_t e;
    logic [1:0] pend_m = '0;
    logic pend_w = 1'b0, pend_s = 1'b0;
    int n_chk = 0, n_fail = 0;
    int n_press0 = 0, n_rel0 = 0, n_wrap_w = 0, n_wrap_s = 0;

    always #5 clk = ~clk;

    pb_debounce_bank #(.NUM_CH(2), .DELAY(4), .LONG_CYCLES(10), .CNT_W(8), .SATURATE(0), .SYNC_STAGES(2)) dut (
        .clock(clk), .reset(reset), .pb_in(pb), .clear(clr), .pb_level(pb_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
        .count(count), .wrap_pulse(wrap_pulse));

    pb_debounce_bank #(.NUM_CH(1), .DELAY(2), .LONG_CYCLES(4), .CNT_W(2), .SATURATE(0), .SYNC_STAGES(2)) dut_w (
        .clock(clk), .reset(reset), .pb_in(pb_w), .clear(clr_w), .pb_level(w_level),
        .press_pulse(w_press), .release_pulse(w_rel), .long_pulse(w_long),
        .count(w_count), .wrap_pulse(w_wrap));

    pb_debounce_bank #(.NUM_CH(1), .DELAY(2), .LONG_CYCLES(4), .CNT_W(2), .SATURATE(1), .SYNC_STAGES(2)) dut_s (
        .clock(clk), .reset(reset), .pb_in(pb_w), .clear(clr_w), .pb_level(s_level),
        .press_pulse(s_press), .release_pulse(s_rel), .long_pulse(s_long),
        .count(s_count), .wrap_pulse(s_wrap));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_release(input int ch, input logic [7:0] exp_cnt);
        q_main.push_back('{ch, exp_cnt, 1'b0});
        pb[ch] = 1'b1;
        tick(12);
        pb[ch] = 1'b0;
        tick(12);
    endtask

    // Scoreboard: the count is checked one cycle after each press pulse the DUT emits
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < 2; c++) begin
            if (pend_m[c]) begin
                chk($sformatf("sb_pending_ch%0d", c), q_main.size() > 0, 1);
                if (q_main.size() > 0) begin
                    e = q_main.pop_front();
                    chk("sb_ch", c, e.ch);
                    chk($sformatf("sb_count_ch%0d", c), count[c*8 +: 8], e.cnt);
                end
            end
            pend_m[c] = press_pulse[c];
        end
        if (pend_w) begin
            chk("w_pending", q_w.size() > 0, 1);
            if (q_w.size() > 0) begin
                e = q_w.pop_front();
                chk("w_count", w_count, e.cnt);
                chk("w_wrap", w_wrap, e.wrap);
            end
        end
        if (pend_s) begin
            chk("s_pending", q_s.size() > 0, 1);
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                chk("s_count", s_count, e.cnt);
                chk("s_wrap", s_wrap, e.wrap);
            end
        end
        pend_w = w_press;
        pend_s = s_press;
        n_press0 += int'(press_pulse[0]);
        n_rel0   += int'(release_pulse[0]);
        n_wrap_w += int'(w_wrap);
        n_wrap_s += int'(s_wrap);
    end

    initial begin
        int base, pc, lc, rc, nl;
        logic seen;
        reset = 1'b0; pb = '0; clr = '0; pb_w = 1'b0; clr_w = 1'b0;
        tick(2);
        chk("rst_level", pb_level, 0);
        chk("rst_pulses", {press_pulse, release_pulse, long_pulse, wrap_pulse}, 0);
        chk("rst_count", count, 0);
        reset = 1'b1;
        tick(3);

        // clean press on ch0
        q_main.push_back('{0, 8'd1, 1'b0});
        pb[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("press0_k%0d", k), press_pulse[0], k == 7);
        end
        chk("level0_on", pb_level[0], 1);
        chk("count0_one", count[7:0], 1);
        chk("ch1_quiet", {pb_level[1], press_pulse[1], release_pulse[1], long_pulse[1], wrap_pulse[1], count[15:8]}, 0);

        // clean release on ch0
        pb[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("release0_k%0d", k), release_pulse[0], k == 7);
        end
        chk("level0_off", pb_level[0], 0);

        // press bounce, then hold
        base = n_press0;
        pb[0] = 1'b1; tick(2); pb[0] = 1'b0; tick(2);
        pb[0] = 1'b1; tick(2); pb[0] = 1'b0; tick(2);
        q_main.push_back('{0, 8'd2, 1'b0});
        pb[0] = 1'b1;
        tick(12);
        chk("bounce_one_press", n_press0 - base, 1);
        chk("bounce_level", pb_level[0], 1);

        // release bounce of 3 low cycles must not release
        base = n_rel0;
        pb[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) pb[0] = 1'b1;
            chk($sformatf("rel_bounce_level_k%0d", k), pb_level[0], 1);
        end
        chk("rel_bounce_no_release", n_rel0 - base, 0);
        pb[0] = 1'b0;
        tick(12);
        chk("count0_two", count[7:0], 2);

        // clear coinciding with a press pulse
        q_main.push_back('{0, 8'd0, 1'b0});
        pb[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = press_pulse[0];
        end
        chk("clr_press_seen", seen, 1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("clr_beats_press", count[7:0], 0);
        tick(12);
        pb[0] = 1'b0;
        tick(12);
        press_release(0, 8'd1);
        chk("count0_before_clear", count[7:0], 1);
        clr[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("clear_held_k%0d", k), count[7:0], 0);
        end
        clr[0] = 1'b0;

        // long press on ch1
        q_main.push_back('{1, 8'd1, 1'b0});
        pb[1] = 1'b1;
        pc = -1; lc = -1; rc = -1; nl = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (press_pulse[1]) pc = k;
            if (long_pulse[1]) begin lc = k; nl++; end
        end
        pb[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (release_pulse[1]) rc = k;
            if (long_pulse[1]) nl++;
        end
        chk("long_press_at", pc, 7);
        chk("long_once", nl, 1);
        chk("long_delay", lc - pc, 10);
        chk("long_release_at", rc, 7);
        chk("long_count1", count[15:8], 1);

        // reset in WAIT_HIGH with deb_timer at 2, button held through release
        pb[0] = 1'b1;
        tick(5);
        reset = 1'b0;
        #1;
        chk("mid_rst_level", pb_level, 0);
        chk("mid_rst_pulses", {press_pulse, release_pulse, long_pulse, wrap_pulse}, 0);
        chk("mid_rst_count", count, 0);
        tick(2);
        chk("mid_rst_no_press", press_pulse, 0);
        q_main.push_back('{0, 8'd1, 1'b0});
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("post_rst_press_k%0d", k), press_pulse[0], k == 7);
        end
        chk("post_rst_count", count[7:0], 1);
        pb[0] = 1'b0;
        tick(12);

        // wrap vs saturate with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            q_w.push_back('{0, 8'((i + 1) % 4), i == 3});
            q_s.push_back('{0, 8'((i + 1) > 3 ? 3 : i + 1), 1'b0});
            pb_w = 1'b1;
            tick(8);
            pb_w = 1'b0;
            tick(8);
        end
        chk("wrap_pulses", n_wrap_w, 1);
        chk("sat_pulses", n_wrap_s, 0);
        chk("wrap_final", w_count, 1);
        chk("sat_final", s_count, 3);

        chk("sb_main_drained", q_main.size(), 0);
        chk("sb_w_drained", q_w.size(), 0);
        chk("sb_s_drained", q_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
